tt_um_accum_tx: RTL and testbench
=================================

TT_UM_ACCUM_TX -- requirements
Module: tt_um_accum_tx

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: the single clock; all state is on its rising edge.
REQ-002 The block SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have `ena`, input, 1 bit: always 1 when powered; unused.
REQ-004 The block SHALL have `ui_in`, input, 8 bits: operand byte added on each load event.
REQ-005 The block SHALL have `uio_in`, input, 8 bits: [0] load strobe (asynchronous), [1] tx_ready from the partner (synchronous to `clk`), [2] clear (synchronous, level), [7:3] unused.
REQ-006 The block SHALL have `uio_out`, output, 8 bits: [4] tx_data, [5] tx_valid, [6] busy, [7] frame_start, [3:0] = 0.
REQ-007 The block SHALL have `uio_oe`, output, 8 bits: constant 8'hF0.
REQ-008 The block SHALL have `uo_out`, output, 8 bits: current accumulator value.

Function
REQ-009 `uio_in[0]` SHALL pass through a 2-flop synchronizer; a load event is a 0->1 transition of the synchronized signal.
REQ-010 The FSM SHALL have states IDLE, LOAD, SHIFT.
- IDLE->LOAD on a load event.
- LOAD->SHIFT unconditionally, after one cycle.
- SHIFT->IDLE on acceptance of the last frame bit.
REQ-011 In LOAD, the block SHALL compute a 9-bit sum {carry, acc + ui_in}.
- `acc` takes the low 8 bits, wrapping modulo 256.
- The 9-bit sum SHALL be loaded into the shift register.
REQ-012 The frame SHALL be sent MSB-first: the carry bit, then acc[7] down to acc[0]. FRAME_BITS = 9.
REQ-013 Latency: `acc`/`uo_out` SHALL update at the 3rd rising `clk` edge after `uio_in[0]` is first sampled high; `tx_valid` SHALL rise at the 4th.
REQ-014 In SHIFT, `tx_valid` = 1 and `tx_data` = the current frame bit.
- A bit is accepted on any edge where `tx_valid` & `tx_ready` are both 1.
- The bit SHALL then advance by one.
- While `tx_ready` = 0, `tx_data` SHALL hold stable.
REQ-015 `frame_start` SHALL be 1 only while the first frame bit is presented.
REQ-016 `busy` SHALL be 1 in LOAD and SHIFT.
REQ-017 Load events occurring while `busy` SHALL be discarded; there is no queuing.
- The edge detector keeps tracking, so a strobe held high across the end of a frame does not retrigger.
REQ-018 Clear = 1 SHALL have priority over all other inputs and SHALL act on the next edge.
- `acc` := 0, shift register := 0, state := IDLE, with an in-flight frame abandoned.
- `tx_valid` SHALL drop on that edge.
REQ-019 A load event coincident with clear SHALL be discarded.
REQ-020 Acceptance of the last bit in the same cycle as a new load event: the load SHALL be discarded, because `busy` was 1.

Reset
REQ-021 While `rst_n` = 0, the block SHALL hold:
- state IDLE, `acc` = 0, shift register = 0, bit counter = 0, synchronizer flops = 0
- `uo_out` = 0, `uio_out` = 0, `uio_oe` = 8'hF0
REQ-022 Reset mid-frame SHALL abort immediately; after release, the block SHALL wait in IDLE for a fresh load edge.

Configuration
REQ-023 With `ACCUM_TX_PARITY_EN` defined, FRAME_BITS SHALL be 10: an even-parity bit, covering the 9 preceding bits, is appended last.
REQ-024 Without `ACCUM_TX_PARITY_EN`, FRAME_BITS SHALL be 9 and no parity logic SHALL exist.

Structure
REQ-025 Package accum_tx_pkg SHALL hold the FSM state encoding, FRAME_BITS (macro-dependent), the counter width and the UIO_OE_MASK = 8'hF0 constant.
REQ-026 The synchronizer plus rising-edge detector SHALL be the sub-module accum_tx_sync_edge; all other logic stays in the top module.

Verification
REQ-027 Reset, then load `ui_in` = 0x05 with `tx_ready` = 1: `uo_out` SHALL = 0x05, and the frame SHALL be 0,0000_0101 over 9 consecutive cycles.
REQ-028 Then load `ui_in` = 0xFF: `uo_out` SHALL = 0x04, and the frame SHALL be 1,0000_0100.
REQ-029 Hold `tx_ready` = 0 for 5 cycles at bit 3: `tx_valid` SHALL stay 1, and `tx_data` SHALL stay constant.
- Resume: the remaining bits SHALL be sent in order.
REQ-030 Raise clear at bit 4, and pulse load during the same frame: `tx_valid` SHALL be 0 the next cycle, and `uo_out` SHALL = 0.
- The discarded pulse SHALL cause no second frame.
REQ-031 Pulse `rst_n` low mid-frame: all outputs SHALL be 0 except `uio_oe` = 8'hF0, and no transmission SHALL occur until the next load edge.
REQ-032 With `ACCUM_TX_PARITY_EN` defined, load 0xFF after 0x05: the frame SHALL be 1,0000_0100,0.

Source files
------------

// File: rtl/accum_tx_pkg.sv
// -----------------------------------------------------------------------------
// accum_tx_pkg
// Shared definitions for the accumulate-and-transmit block:
//   - state_e      : FSM state encoding (IDLE, LOAD, SHIFT)
//   - FRAME_BITS   : serial frame length (9, or 10 with ACCUM_TX_PARITY_EN)
//   - CNT_W        : width of the frame bit counter
//   - UIO_OE_MASK  : constant output-enable pattern for the uio pins
// Optional feature macro: ACCUM_TX_PARITY_EN (appends an even-parity bit).
// -----------------------------------------------------------------------------
package accum_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

`ifdef ACCUM_TX_PARITY_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 9;
`endif

  localparam int CNT_W = $clog2(FRAME_BITS);

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

`ifdef ACCUM_TX_PARITY_EN
  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [8:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/accum_tx_if.sv
// -----------------------------------------------------------------------------
// accum_tx_if
// Serial transmit link of the accumulator block.
//   tx_data     : current frame bit (sender -> receiver)
//   tx_valid    : frame bit is valid (sender -> receiver)
//   frame_start : first frame bit is being presented (sender -> receiver)
//   busy        : sender is loading or shifting a frame (sender -> receiver)
//   tx_ready    : receiver accepts the bit on this edge (receiver -> sender)
// -----------------------------------------------------------------------------
interface accum_tx_if;

  logic tx_data;
  logic tx_valid;
  logic frame_start;
  logic busy;
  logic tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output frame_start,
    output busy,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  frame_start,
    input  busy,
    output tx_ready
  );

endinterface

// File: rtl/accum_tx_sync_edge.sv
// -----------------------------------------------------------------------------
// accum_tx_sync_edge
// Two-flop synchronizer followed by a rising-edge detector.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (clears all flops)
//   i_async  : asynchronous input strobe
//   o_rise   : one-cycle pulse when the synchronized signal goes 0 -> 1
// The detector keeps tracking regardless of downstream state, so a strobe
// that stays high produces exactly one pulse.
// -----------------------------------------------------------------------------
module accum_tx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronizer chain and delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/tt_um_accum_tx.sv
// -----------------------------------------------------------------------------
// tt_um_accum_tx
// Accumulates ui_in on each load strobe edge and transmits the 9-bit result
// {carry, acc} MSB-first over a valid/ready serial link.
// Ports:
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : always 1 when powered, unused
//   ui_in    : operand added on each load event
//   uio_in   : [0] load strobe (async), [1] tx_ready, [2] clear, [7:3] unused
//   uio_out  : [4] tx_data, [5] tx_valid, [6] busy, [7] frame_start, [3:0] 0
//   uio_oe   : constant 8'hF0
//   uo_out   : accumulator value
// Optional feature macro: ACCUM_TX_PARITY_EN (10-bit frame with trailing
// even-parity bit over the 9 preceding bits).
// -----------------------------------------------------------------------------
module tt_um_accum_tx
  import accum_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  state_e                r_state;
  logic [7:0]            r_acc;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_frame_start;

  logic                  w_load_evt;
  logic                  w_tx_ready;
  logic                  w_clear;
  logic                  w_accept;
  logic                  w_last;
  logic [8:0]            w_sum;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_unused_ok;

  accum_tx_sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (uio_in[0]),
    .o_rise  (w_load_evt)
  );

  assign w_tx_ready = uio_in[1];
  assign w_clear    = uio_in[2];

  // tx_valid is only ever set in SHIFT, so it alone qualifies acceptance.
  assign w_accept = r_tx_valid & w_tx_ready;
  assign w_last   = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

  assign w_sum = {1'b0, r_acc} + {1'b0, ui_in};

`ifdef ACCUM_TX_PARITY_EN
  assign w_frame = {w_sum, even_parity(w_sum)};
`else
  assign w_frame = w_sum;
`endif

  // Main FSM: the sum is captured on the edge entering LOAD so that acc is
  // visible three edges after the strobe is first sampled; tx_valid follows
  // one edge later on entry to SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_acc         <= 8'd0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_tx_data     <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_clear) begin
      // Clear wins over everything, including a coincident load event.
      r_state       <= ST_IDLE;
      r_acc         <= 8'd0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_tx_data     <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Load events are only honoured here; while busy they are dropped.
          if (w_load_evt) begin
            r_state <= ST_LOAD;
            r_acc   <= w_sum[7:0];
            r_shreg <= w_frame;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state       <= ST_SHIFT;
          r_tx_valid    <= 1'b1;
          r_tx_data     <= r_shreg[FRAME_BITS-1];
          r_frame_start <= 1'b1;
          r_bit_cnt     <= '0;
        end
        ST_SHIFT: begin
          if (w_accept) begin
            r_frame_start <= 1'b0;
            if (w_last) begin
              r_state    <= ST_IDLE;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 1'b0;
              r_busy     <= 1'b0;
              r_bit_cnt  <= '0;
              r_shreg    <= '0;
            end else begin
              r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
              r_tx_data <= r_shreg[FRAME_BITS-2];
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_tx_valid    <= 1'b0;
          r_tx_data     <= 1'b0;
          r_busy        <= 1'b0;
          r_frame_start <= 1'b0;
          r_bit_cnt     <= '0;
        end
      endcase
    end
  end

  assign uo_out  = r_acc;
  assign uio_out = {r_frame_start, r_busy, r_tx_valid, r_tx_data, 4'b0000};
  assign uio_oe  = UIO_OE_MASK;

  assign w_unused_ok = &{1'b0, ena, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_accum_tx.sv
// -----------------------------------------------------------------------------
// tb_tt_um_accum_tx
// Self-checking bench for tt_um_accum_tx. A behavioural model keeps the
// expected accumulator as an integer and derives each expected frame from the
// arithmetic sum; the serial link is observed through accum_tx_if.
// -----------------------------------------------------------------------------
module tb_tt_um_accum_tx;

`ifdef ACCUM_TX_PARITY_EN
  localparam int FB = 10;
`else
  localparam int FB = 9;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  logic       strobe;
  logic       clear;

  int n_checks;
  int n_errors;

  int            exp_acc;
  logic [FB-1:0] exp_frame;

  accum_tx_if u_link ();

  assign u_link.tx_data     = uio_out[4];
  assign u_link.tx_valid    = uio_out[5];
  assign u_link.busy        = uio_out[6];
  assign u_link.frame_start = uio_out[7];
  assign uio_in = {5'b00000, clear, u_link.tx_ready, strobe};

  tt_um_accum_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame for a 9-bit sum: carry then acc MSB-first, plus parity.
  function automatic logic [FB-1:0] frame_of(input int sum);
    logic [8:0] s9;
    s9 = sum[8:0];
`ifdef ACCUM_TX_PARITY_EN
    return {s9, ^s9};
`else
    return s9;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load strobe with operand v and check the latency of acc/tx_valid.
  task automatic do_load(input logic [7:0] v, input bit keep_high);
    int sum;
    ui_in  = v;
    strobe = 1'b1;
    tick();                                   // E1: strobe first sampled
    tick();                                   // E2
    chk("acc_before_e3", uo_out, exp_acc[7:0]);
    tick();                                   // E3
    sum       = exp_acc + int'(v);
    exp_frame = frame_of(sum);
    exp_acc   = sum % 256;
    chk("acc_at_e3", uo_out, exp_acc[7:0]);
    chk("busy_at_e3", uio_out[6], 1);
    chk("valid_before_e4", uio_out[5], 0);
    tick();                                   // E4
    chk("valid_at_e4", u_link.tx_valid, 1);
    if (!keep_high) strobe = 1'b0;
  endtask

  // Receive frame bits start_idx..stop_at-1, optionally stalling.
  task automatic rx_frame(input int start_idx, input int stop_at,
                          input int stall_idx, input int stall_len, input bit rnd);
    int  idx;
    int  cyc;
    int  stalled;
    bit  rdy;
    idx     = start_idx;
    cyc     = 0;
    stalled = 0;
    while (idx < stop_at && cyc < 400) begin
      chk("tx_valid", u_link.tx_valid, 1);
      chk("tx_data", u_link.tx_data, exp_frame[FB-1-idx]);
      chk("frame_start", u_link.frame_start, (idx == 0) ? 1 : 0);
      chk("acc_stable", uo_out, exp_acc[7:0]);
      if (idx == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      u_link.tx_ready = rdy;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    chk("rx_progress", idx, stop_at);
    if (stop_at == FB) begin
      chk("valid_after_frame", u_link.tx_valid, 0);
      chk("busy_after_frame", u_link.busy, 0);
      chk("fstart_after_frame", u_link.frame_start, 0);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, u_link.tx_valid, 0);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    exp_acc         = 0;
    exp_frame       = '0;
    ena             = 1'b1;
    ui_in           = 8'h00;
    strobe          = 1'b0;
    clear           = 1'b0;
    u_link.tx_ready = 1'b1;
    rst_n           = 1'b0;
    #23;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();
    tick();

    // Directed: 0x05 then 0xFF (wraps to 0x04 with carry).
    do_load(8'h05, 1'b0);
    chk("acc_05", uo_out, 8'h05);
    chk("frame_05", {23'd0, exp_frame[FB-1 -: 9]}, 32'h005);
    rx_frame(0, FB, -1, 0, 1'b0);
    do_load(8'hFF, 1'b0);
    chk("acc_ff", uo_out, 8'h04);
    chk("frame_ff", {23'd0, exp_frame[FB-1 -: 9]}, 32'h104);
    rx_frame(0, FB, -1, 0, 1'b0);

    // Back-pressure: ready low for 5 cycles at bit 3.
    do_load(8'h3C, 1'b0);
    rx_frame(0, FB, 3, 5, 1'b0);

    // Strobe held high across the end of a frame must not retrigger.
    do_load(8'hA7, 1'b1);
    rx_frame(0, FB, -1, 0, 1'b0);
    idle_check(8, "no_retrigger");
    strobe = 1'b0;
    tick();
    tick();
    tick();

    // Clear at bit 4 with a discarded load pulse inside the same frame.
    do_load(8'h5A, 1'b0);
    rx_frame(0, 2, -1, 0, 1'b0);
    strobe = 1'b1;
    rx_frame(2, 4, -1, 0, 1'b0);
    strobe          = 1'b0;
    clear           = 1'b1;
    u_link.tx_ready = 1'b0;
    tick();
    clear   = 1'b0;
    exp_acc = 0;
    chk("clear_valid", u_link.tx_valid, 0);
    chk("clear_acc", uo_out, 8'h00);
    chk("clear_busy", u_link.busy, 0);
    u_link.tx_ready = 1'b1;
    idle_check(12, "no_frame_after_clear");
    chk("acc_after_clear", uo_out, 8'h00);

    // Load event coincident with clear is discarded.
    ui_in  = 8'h11;
    strobe = 1'b1;
    clear  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    clear = 1'b0;
    idle_check(10, "no_frame_clear_coincident");
    chk("acc_clear_coincident", uo_out, 8'h00);
    strobe = 1'b0;
    tick();
    tick();
    tick();

    // Reset mid-frame.
    do_load(8'h81, 1'b0);
    rx_frame(0, 3, -1, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_uo_out", uo_out, 8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    chk("midrst_uio_oe", uio_oe, 8'hF0);
    exp_acc = 0;
    tick();
    tick();
    rst_n = 1'b1;
    idle_check(10, "no_frame_after_reset");
    chk("acc_after_reset", uo_out, 8'h00);

    // Randomized loads with random back-pressure.
    for (int k = 0; k < 10; k++) begin
      do_load(8'($urandom_range(0, 255)), 1'b0);
      rx_frame(0, FB, -1, 0, 1'b1);
      u_link.tx_ready = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
